bp_update_queue: RTL and testbench

Buffers resolved-branch outcomes from up to three branch FUs per cycle and drains them one per cycle into the branch predictor's single update port. It sits between the branch FUs and the predictor, enforcing age order, providing backpressure, and discarding pending updates on a pipeline flush.

---
 rtl/bp_update_queue_pkg.sv | 13 +
 rtl/bp_update_queue_if.sv | 30 +++
 rtl/bp_update_queue.sv | 99 +++++++++
 tb/tb_bp_update_queue.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bp_update_queue_pkg.sv
// Shared types and default sizing for the branch-predictor update queue.
package bp_update_queue_pkg;
    localparam int BPQ_DEPTH = 8;
    localparam int BPQ_NIN   = 3;
    localparam int BP_XLEN   = 32;

    // Same packet shape the predictor's update port consumes.
    typedef struct packed {
        logic [BP_XLEN-1:0] pc;
        logic               direction;
        logic [BP_XLEN-1:0] target;
    } bp_update_packet_t;
endpackage

// File: rtl/bp_update_queue_if.sv
// Branch-FU side and predictor side of the update queue.
interface bp_update_queue_if #(
    parameter int DEPTH = 8,
    parameter int NIN   = 3,
    parameter int XLEN  = 32
);
    logic                           flush;
    logic [NIN-1:0]                 in_valid;
    logic [NIN-1:0][XLEN-1:0]       in_pc;
    logic [NIN-1:0]                 in_direction;
    logic [NIN-1:0][XLEN-1:0]       in_target;
    logic                           in_ready;
    logic                           update_EN;
    logic [XLEN-1:0]                update_pc;
    logic                           update_direction;
    logic [XLEN-1:0]                update_target;
    logic [$clog2(DEPTH):0]         count;
    logic                           overflow_err;

    modport master (
        output flush, in_valid, in_pc, in_direction, in_target,
        input  in_ready, update_EN, update_pc, update_direction, update_target,
               count, overflow_err
    );
    modport slave (
        input  flush, in_valid, in_pc, in_direction, in_target,
        output in_ready, update_EN, update_pc, update_direction, update_target,
               count, overflow_err
    );
endinterface

// File: rtl/bp_update_queue.sv
// Age-ordered FIFO that merges up to NIN resolved branches per cycle and
// drains one registered update per cycle into the branch predictor.
module bp_update_queue
    import bp_update_queue_pkg::*;
#(
    parameter int DEPTH = BPQ_DEPTH,
    parameter int NIN   = BPQ_NIN,
    parameter int XLEN  = BP_XLEN
) (
    input  logic             clock,
    input  logic             reset_n,
    bp_update_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] READY_MAX = (AW+1)'(DEPTH - NIN);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            direction;
        logic [XLEN-1:0] target;
    } entry_t;

    entry_t                 mem [DEPTH];
    logic [AW-1:0]          head, tail;
    logic [AW:0]            count_q;
    logic [NIN-1:0][AW-1:0] lane_off;
    logic [AW:0]            nvalid;
    logic                   ready, any_valid, accept, drop, pop;
    logic                   upd_en, upd_dir, ovf;
    logic [XLEN-1:0]        upd_pc, upd_tgt;

    // Oldest lane is the highest index; each valid lane's slot offset is the
    // number of valid lanes older than it.
    always_comb begin
        nvalid   = '0;
        lane_off = '0;
        for (int i = NIN-1; i >= 0; i--) begin
            lane_off[i] = nvalid[AW-1:0];
            nvalid      = nvalid + (AW+1)'(bus.in_valid[i]);
        end
    end

    // Readiness uses the registered count only, so a same-cycle pop never helps.
    assign ready     = (count_q <= READY_MAX);
    assign any_valid = |bus.in_valid;
    assign accept    = any_valid & ready & ~bus.flush;
    assign drop      = any_valid & ~ready & ~bus.flush;
    assign pop       = (count_q != '0) & ~bus.flush;

    always_ff @(posedge clock) begin
        if (accept) begin
            for (int i = 0; i < NIN; i++) begin
                if (bus.in_valid[i])
                    mem[tail + lane_off[i]] <= '{pc: bus.in_pc[i],
                                                 direction: bus.in_direction[i],
                                                 target: bus.in_target[i]};
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            upd_en  <= 1'b0;
            upd_pc  <= '0;
            upd_dir <= 1'b0;
            upd_tgt <= '0;
            ovf     <= 1'b0;
        end else if (bus.flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            upd_en  <= 1'b0;
        end else begin
            if (accept)
                tail <= tail + nvalid[AW-1:0];
            if (pop) begin
                head    <= head + AW'(1);
                upd_pc  <= mem[head].pc;
                upd_dir <= mem[head].direction;
                upd_tgt <= mem[head].target;
            end
            upd_en  <= pop;
            count_q <= count_q + (accept ? nvalid : '0) - (AW+1)'(pop);
            if (drop)
                ovf <= 1'b1;
        end
    end

    assign bus.in_ready         = ready;
    assign bus.update_EN        = upd_en;
    assign bus.update_pc        = upd_pc;
    assign bus.update_direction = upd_dir;
    assign bus.update_target    = upd_tgt;
    assign bus.count            = count_q;
    assign bus.overflow_err     = ovf;
endmodule

// File: tb/tb_bp_update_queue.sv
// Scoreboard bench for bp_update_queue: driver pushes expected packets, a
// negedge monitor pops and compares whenever update_EN is high.
module tb_bp_update_queue;
    import bp_update_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int NIN   = 3;
    localparam int XLEN  = 32;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    bp_update_queue_if #(.DEPTH(DEPTH), .NIN(NIN), .XLEN(XLEN)) bus ();

    bp_update_queue #(.DEPTH(DEPTH), .NIN(NIN), .XLEN(XLEN)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    bp_update_packet_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n && bus.update_EN === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_update: got pc %0h expected no update", bus.update_pc);
            end else begin
                bp_update_packet_t e;
                e = sb.pop_front();
                chk("update_pc", bus.update_pc, e.pc);
                chk("update_direction", 32'(bus.update_direction), 32'(e.direction));
                chk("update_target", bus.update_target, e.target);
            end
        end
    end

    task automatic clear_in();
        bus.flush        = 1'b0;
        bus.in_valid     = '0;
        bus.in_pc        = '0;
        bus.in_direction = '0;
        bus.in_target    = '0;
    endtask

    // Call in age order (lane 2, 1, 0) so the scoreboard order matches.
    task automatic lane(input int l, input logic [31:0] pc, input logic dir,
                        input logic [31:0] tgt, input bit expect_out);
        bp_update_packet_t p;
        bus.in_valid[l]     = 1'b1;
        bus.in_pc[l]        = pc;
        bus.in_direction[l] = dir;
        bus.in_target[l]    = tgt;
        p.pc = pc; p.direction = dir; p.target = tgt;
        if (expect_out) sb.push_back(p);
    endtask

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_cnt[4];
        exp_cnt = '{3, 5, 7, 6};
        clear_in();
        repeat (2) @(negedge clock);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_update_EN", 32'(bus.update_EN), 0);
        chk("rst_overflow", 32'(bus.overflow_err), 0);
        chk("rst_update_pc", bus.update_pc, 0);
        reset_n = 1'b1;
        cyc();

        // single entry latency
        lane(2, 32'h40, 1'b1, 32'h80, 1);
        cyc(); clear_in();
        chk("t1_en_E0", 32'(bus.update_EN), 0);
        chk("t1_count_E0", 32'(bus.count), 1);
        cyc();
        chk("t1_en_E1", 32'(bus.update_EN), 1);
        cyc();
        chk("t1_en_idle", 32'(bus.update_EN), 0);
        chk("t1_count_idle", 32'(bus.count), 0);

        // three-lane group drains oldest first
        lane(2, 32'h10, 1'b0, 32'h110, 1);
        lane(1, 32'h20, 1'b1, 32'h120, 1);
        lane(0, 32'h30, 1'b0, 32'h130, 1);
        cyc(); clear_in();
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t2_en_drain", 32'(bus.update_EN), 1);
        end
        cyc();
        chk("t2_en_done", 32'(bus.update_EN), 0);
        chk("t2_count_done", 32'(bus.count), 0);

        // fill with groups of 3; fourth group is dropped
        for (int g = 0; g < 4; g++) begin
            chk("t3_in_ready", 32'(bus.in_ready), (g < 3) ? 1 : 0);
            for (int l = NIN-1; l >= 0; l--)
                lane(l, 32'h100 + 32'(g*16) + 32'(2-l), l[0], 32'h900 + 32'(g*16 + l), g < 3);
            cyc(); clear_in();
            chk("t3_count", 32'(bus.count), 32'(exp_cnt[g]));
        end
        chk("t3_in_ready_at6", 32'(bus.in_ready), 0);
        chk("t3_overflow", 32'(bus.overflow_err), 1);
        repeat (8) cyc();
        chk("t3_count_drained", 32'(bus.count), 0);
        chk("t3_sb_empty", 32'(sb.size()), 0);
        chk("t3_in_ready_empty", 32'(bus.in_ready), 1);

        // steady one-per-cycle, pointers wrap
        for (int k = 0; k < 12; k++) begin
            lane(0, 32'h200 + 32'(k*4), k[0], 32'h300 + 32'(k), 1);
            cyc();
            if (k > 0) chk("t4_en_steady", 32'(bus.update_EN), 1);
            chk("t4_count_steady", 32'(bus.count), 1);
        end
        clear_in();
        cyc();
        chk("t4_en_last", 32'(bus.update_EN), 1);
        chk("t4_count_last", 32'(bus.count), 0);
        cyc();
        chk("t4_en_idle", 32'(bus.update_EN), 0);

        // flush with 5 queued and a same-cycle group
        for (int l = NIN-1; l >= 0; l--)
            lane(l, 32'h500 + 32'(2-l), 1'b1, 32'h600 + 32'(l), l == 2);
        cyc(); clear_in();
        for (int l = NIN-1; l >= 0; l--)
            lane(l, 32'h510 + 32'(2-l), 1'b0, 32'h610 + 32'(l), 0);
        cyc(); clear_in();
        chk("t5_count_pre", 32'(bus.count), 5);
        bus.flush = 1'b1;
        for (int l = NIN-1; l >= 0; l--)
            lane(l, 32'h520 + 32'(2-l), 1'b1, 32'h620 + 32'(l), 0);
        cyc(); clear_in();
        chk("t5_count_flush", 32'(bus.count), 0);
        chk("t5_en_flush", 32'(bus.update_EN), 0);
        chk("t5_overflow_kept", 32'(bus.overflow_err), 1);
        repeat (4) cyc();
        chk("t5_count_after", 32'(bus.count), 0);
        chk("t5_sb_empty", 32'(sb.size()), 0);

        // asynchronous reset with 4 queued
        for (int l = NIN-1; l >= 0; l--)
            lane(l, 32'h700 + 32'(2-l), 1'b0, 32'h800 + 32'(l), l == 2);
        cyc(); clear_in();
        lane(2, 32'h710, 1'b1, 32'h810, 0);
        lane(1, 32'h711, 1'b0, 32'h811, 0);
        cyc(); clear_in();
        chk("t6_count_pre", 32'(bus.count), 4);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_count_async", 32'(bus.count), 0);
        chk("t6_en_async", 32'(bus.update_EN), 0);
        chk("t6_pc_async", bus.update_pc, 0);
        chk("t6_overflow_async", 32'(bus.overflow_err), 0);
        chk("t6_in_ready_async", 32'(bus.in_ready), 1);
        @(negedge clock);
        reset_n = 1'b1;
        cyc();
        chk("t6_count_rel", 32'(bus.count), 0);
        chk("t6_in_ready_rel", 32'(bus.in_ready), 1);
        chk("t6_en_rel", 32'(bus.update_EN), 0);
        chk("t6_sb_empty", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
